wr_burst_drain: RTL



---
 rtl/wr_burst_drain.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/wr_burst_drain.sv
// wr_burst_drain
//   Read-side drain engine for the DDR3 write-path FIFO. Waits until a full
//   burst is buffered, then issues one write command and streams exactly
//   BURST_LEN data beats, popping the FIFO through a 2-entry prefetch buffer.
//   The command address advances per burst and wraps to ADDR_BASE before a
//   burst could run past ADDR_MAX.
//
// Ports
//   clk, rst             : clock (FIFO rd_clk), async active-high reset
//   enable               : permits starting new bursts (sampled in IDLE only)
//   fifo_rd_en           : FIFO pop
//   fifo_rd_data         : FIFO data, valid the cycle after fifo_rd_en
//   fifo_rd_empty        : FIFO empty
//   fifo_rd_water_level  : words available in the FIFO
//   cmd_valid/cmd_ready  : command handshake, cmd_addr/cmd_len payload
//   wdata_valid/ready    : data handshake, wdata/wdata_last payload
//   busy                 : engine not idle
//   burst_done           : one-cycle pulse after the last beat is accepted
module wr_burst_drain #(
    parameter int unsigned           DATA_WIDTH  = 128,
    parameter int unsigned           LEVEL_WIDTH = 11,
    parameter int unsigned           BURST_LEN   = 16,
    parameter int unsigned           ADDR_WIDTH  = 28,
    parameter int unsigned           ADDR_STEP   = 8,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE   = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_MAX    = 28'h0FF_FFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_rd_empty,
    input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [ADDR_WIDTH-1:0]  cmd_addr,
    output logic [6:0]             cmd_len,
    output logic                   wdata_valid,
    input  logic                   wdata_ready,
    output logic [DATA_WIDTH-1:0]  wdata,
    output logic                   wdata_last,
    output logic                   busy,
    output logic                   burst_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_DATA
    } state_t;

    localparam logic [6:0]             LEN7       = 7'(BURST_LEN);
    localparam logic [LEVEL_WIDTH-1:0] LVL_NEED   = LEVEL_WIDTH'(BURST_LEN);
    localparam int unsigned            AW2        = ADDR_WIDTH + 2;
    localparam logic [AW2-1:0]         BURST_SPAN = AW2'(BURST_LEN * ADDR_STEP);
    localparam logic [AW2-1:0]         MAX_EXT    = AW2'(ADDR_MAX);

    state_t                  r_state;
    logic                    r_cmd_valid;
    logic                    r_burst_done;
    logic [ADDR_WIDTH-1:0]   r_cmd_addr;
    logic [6:0]              r_fetch_cnt;
    logic [6:0]              r_beat_cnt;
    logic                    r_pending;
    logic [DATA_WIDTH-1:0]   r_buf0;
    logic [DATA_WIDTH-1:0]   r_buf1;
    logic                    r_head;
    logic [1:0]              r_count;

    logic                    w_wdata_valid;
    logic                    w_beat_fire;
    logic                    w_last_fire;
    logic [1:0]              w_credit;
    logic                    w_rd_en;
    logic                    w_wr_idx;
    logic [AW2-1:0]          w_next_ext;
    logic                    w_wrap;
    logic [ADDR_WIDTH-1:0]   w_next_addr;

    assign w_wdata_valid = (r_state == S_DATA) && (r_count != 2'd0);
    assign w_beat_fire   = w_wdata_valid && wdata_ready;
    assign w_last_fire   = w_beat_fire && wdata_last;

    // Credit covers words already buffered plus the pop whose data lands next
    // cycle; a full buffer may still pop when a beat drains it this cycle.
    assign w_credit = r_count + {1'b0, r_pending};
    assign w_rd_en  = (r_state != S_IDLE) && (r_fetch_cnt != 7'd0) && !fifo_rd_empty &&
                      ((w_credit < 2'd2) || ((w_credit == 2'd2) && w_beat_fire));

    // Incoming word goes to the slot behind the head; with a full buffer no
    // word is ever in flight, so count[0] alone selects the slot.
    assign w_wr_idx = r_head ^ r_count[0];

    // Wrap when the following burst would run past ADDR_MAX.
    assign w_next_ext  = AW2'(r_cmd_addr) + BURST_SPAN;
    assign w_wrap      = (w_next_ext + BURST_SPAN - AW2'(1)) > MAX_EXT;
    assign w_next_addr = w_wrap ? ADDR_BASE : w_next_ext[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cmd_valid  <= 1'b0;
            r_burst_done <= 1'b0;
            r_cmd_addr   <= ADDR_BASE;
            r_fetch_cnt  <= '0;
            r_beat_cnt   <= '0;
            r_pending    <= 1'b0;
            r_buf0       <= '0;
            r_buf1       <= '0;
            r_head       <= 1'b0;
            r_count      <= '0;
        end else begin
            r_pending    <= w_rd_en;
            r_burst_done <= 1'b0;

            if (r_pending) begin
                if (w_wr_idx) r_buf1 <= fifo_rd_data;
                else          r_buf0 <= fifo_rd_data;
            end
            if (w_beat_fire) r_head <= ~r_head;
            r_count <= r_count + {1'b0, r_pending} - {1'b0, w_beat_fire};

            if (w_rd_en) r_fetch_cnt <= r_fetch_cnt - 7'd1;

            case (r_state)
                S_IDLE: begin
                    // The water level lags the pops of the burst just finished,
                    // so the cycle carrying burst_done never starts a new one.
                    if (enable && (fifo_rd_water_level >= LVL_NEED) && !r_burst_done) begin
                        r_state     <= S_CMD;
                        r_cmd_valid <= 1'b1;
                        r_fetch_cnt <= LEN7;
                        r_beat_cnt  <= '0;
                    end
                end
                S_CMD: begin
                    if (cmd_ready) begin
                        r_state     <= S_DATA;
                        r_cmd_valid <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (w_beat_fire) r_beat_cnt <= r_beat_cnt + 7'd1;
                    if (w_last_fire) begin
                        r_state      <= S_IDLE;
                        r_burst_done <= 1'b1;
                        r_cmd_addr   <= w_next_addr;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fifo_rd_en  = w_rd_en;
    assign cmd_valid   = r_cmd_valid;
    assign cmd_addr    = r_cmd_addr;
    assign cmd_len     = LEN7;
    assign wdata_valid = w_wdata_valid;
    assign wdata       = r_head ? r_buf1 : r_buf0;
    assign wdata_last  = w_wdata_valid && (r_beat_cnt == (LEN7 - 7'd1));
    assign busy        = (r_state != S_IDLE);
    assign burst_done  = r_burst_done;

endmodule
